// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the carry-save multiplier resolve stage: the default
// operand width, the derived row/product widths and the stage-1 payload that
// carries a half-resolved row pair between the two adder stages.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int W      = 4;
    localparam int ROW_W  = 2 * W;
    localparam int PROD_W = 2 * W + 1;

    // Low half already added (lo + c1). High halves are kept raw for stage 2.
    typedef struct packed {
        logic [W-1:0] lo;
        logic         c1;
        logic [W-1:0] hi_a;
        logic [W-1:0] hi_b;
        logic         acc;
    } s1_payload_t;

endpackage

// File: rtl/mult_cs_resolve_mac_if.sv
// -----------------------------------------------------------------------------
// mult_cs_resolve_mac_if
// Bundles the input row-pair handshake and the output result handshake of the
// resolve/accumulate stage.
//   master : drives in_valid/in_row_a/in_row_b/in_acc and out_ready
//   slave  : drives in_ready and out_valid/out_sum/out_acc/out_ovf
// -----------------------------------------------------------------------------
interface mult_cs_resolve_mac_if #(
    parameter int W     = mult_pkg::W,
    parameter int ACC_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   in_row_a;
    logic [2*W-1:0]   in_row_b;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [2*W:0]     out_sum;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output in_valid, in_row_a, in_row_b, in_acc, out_ready,
        input  in_ready, out_valid, out_sum, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_row_a, in_row_b, in_acc, out_ready,
        output in_ready, out_valid, out_sum, out_acc, out_ovf
    );

endinterface

// File: rtl/mult_split_cpa.sv
// -----------------------------------------------------------------------------
// mult_split_cpa
// Combinational N-bit slice of the carry-propagate adder: a + b + cin.
//   a_i, b_i : N-bit addends
//   cin_i    : carry in from the lower slice
//   sum_o    : N-bit sum
//   cout_o   : carry out to the upper slice
// -----------------------------------------------------------------------------
module mult_split_cpa #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/mult_cs_resolve_mac.sv
// -----------------------------------------------------------------------------
// mult_cs_resolve_mac
// Resolves the two redundant rows of the 4x4 carry-save multiplier into the
// full product with a two-stage pipelined adder (low half, then high half plus
// carry) and optionally accumulates each product into a wrapping running sum.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mult_cs_resolve_mac_if (row pair in, result out)
// W must equal mult_pkg::W because the stage-1 payload type is sized by it.
// -----------------------------------------------------------------------------
module mult_cs_resolve_mac #(
    parameter int W     = 4,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_cs_resolve_mac_if.slave  bus
);

    import mult_pkg::*;

    s1_payload_t       s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              adv1, adv2;
    logic [W-1:0]      lo_sum, hi_sum;
    logic              lo_carry, hi_carry;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext, acc_add;
    logic              acc_carry;

    // A stage may load whenever it is empty or its contents leave this cycle.
    assign adv2         = !s2_valid_q || bus.out_ready;
    assign adv1         = !s1_valid_q || adv2;
    assign bus.in_ready = adv1;

    mult_split_cpa #(.N(W)) u_cpa_lo (
        .a_i    (bus.in_row_a[W-1:0]),
        .b_i    (bus.in_row_b[W-1:0]),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (lo_carry)
    );

    mult_split_cpa #(.N(W)) u_cpa_hi (
        .a_i    (s1_q.hi_a),
        .b_i    (s1_q.hi_b),
        .cin_i  (s1_q.c1),
        .sum_o  (hi_sum),
        .cout_o (hi_carry)
    );

    // The high-half carry becomes the top product bit, so nothing is truncated.
    assign prod     = {hi_carry, hi_sum, s1_q.lo};
    assign prod_ext = ACC_W'(prod);
    assign {acc_carry, acc_add} = {1'b0, acc_q} + {1'b0, prod_ext};

    // Next-state for both stages. Everything holds by default; the accumulator
    // only moves when stage 2 actually takes a new beat, so a stall can never
    // add the same product twice.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.lo   = lo_sum;
                s1_d.c1   = lo_carry;
                s1_d.hi_a = bus.in_row_a[ROW_W-1:W];
                s1_d.hi_b = bus.in_row_b[ROW_W-1:W];
                s1_d.acc  = bus.in_acc;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d = prod;
                if (s1_q.acc) begin
                    acc_d = acc_add;
                    ovf_d = ovf_q | acc_carry;
                end else begin
                    acc_d = prod_ext;
                    ovf_d = 1'b0;
                end
            end
        end
    end

    // Pipeline registers; reset wins over any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_cs_resolve_mac.sv
// -----------------------------------------------------------------------------
// tb_mult_cs_resolve_mac
// Drives two instances of the resolve stage (16-bit and 10-bit accumulator).
// A reference model per instance predicts sum/acc/ovf when a beat is accepted
// and queues it; results are popped and compared when they leave the DUT.
// -----------------------------------------------------------------------------
module tb_mult_cs_resolve_mac;

    import mult_pkg::*;

    typedef struct packed {
        logic [8:0]  sum;
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mult_cs_resolve_mac_if #(.W(W), .ACC_W(16)) bus ();
    mult_cs_resolve_mac_if #(.W(W), .ACC_W(10)) bus10 ();

    mult_cs_resolve_mac #(.W(W), .ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mult_cs_resolve_mac #(.W(W), .ACC_W(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    exp_t q16[$];
    exp_t q10[$];
    int   mAcc16, mAcc10, s16, s10, t16, t10;
    bit   mOvf16, mOvf10;
    exp_t e16, e10;

    // Scoreboard for the 16-bit instance. Transfers are judged half a cycle
    // before the edge that performs them; reset flushes model and queue.
    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
            mAcc16 = 0;
            mOvf16 = 1'b0;
        end else begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                compared++;
                if (q16.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb16_unexpected: got sum %h with nothing expected", bus.out_sum);
                end else begin
                    e16 = q16.pop_front();
                    if (bus.out_sum !== e16.sum || bus.out_acc !== e16.acc || bus.out_ovf !== e16.ovf) begin
                        mismatched++;
                        $display("[TB] FAIL sb16: got sum/acc/ovf %h/%0d/%b, expected %h/%0d/%b",
                                 bus.out_sum, bus.out_acc, bus.out_ovf, e16.sum, e16.acc, e16.ovf);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                s16 = int'(bus.in_row_a) + int'(bus.in_row_b);
                if (bus.in_acc) begin
                    t16    = mAcc16 + s16;
                    mOvf16 = mOvf16 | (t16 >= 65536);
                    mAcc16 = t16 % 65536;
                end else begin
                    mAcc16 = s16;
                    mOvf16 = 1'b0;
                end
                e16.sum = 9'(s16);
                e16.acc = 16'(mAcc16);
                e16.ovf = mOvf16;
                q16.push_back(e16);
            end
        end
    end

    // Same scoreboard for the 10-bit instance.
    always @(negedge clk) begin
        if (rst) begin
            q10.delete();
            mAcc10 = 0;
            mOvf10 = 1'b0;
        end else begin
            if (bus10.out_valid === 1'b1 && bus10.out_ready === 1'b1) begin
                compared++;
                if (q10.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb10_unexpected: got sum %h with nothing expected", bus10.out_sum);
                end else begin
                    e10 = q10.pop_front();
                    if (bus10.out_sum !== e10.sum || bus10.out_acc !== e10.acc[9:0] || bus10.out_ovf !== e10.ovf) begin
                        mismatched++;
                        $display("[TB] FAIL sb10: got sum/acc/ovf %h/%0d/%b, expected %h/%0d/%b",
                                 bus10.out_sum, bus10.out_acc, bus10.out_ovf, e10.sum, e10.acc, e10.ovf);
                    end
                end
            end
            if (bus10.in_valid === 1'b1 && bus10.in_ready === 1'b1) begin
                s10 = int'(bus10.in_row_a) + int'(bus10.in_row_b);
                if (bus10.in_acc) begin
                    t10    = mAcc10 + s10;
                    mOvf10 = mOvf10 | (t10 >= 1024);
                    mAcc10 = t10 % 1024;
                end else begin
                    mAcc10 = s10;
                    mOvf10 = 1'b0;
                end
                e10.sum = 9'(s10);
                e10.acc = 16'(mAcc10);
                e10.ovf = mOvf10;
                q10.push_back(e10);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus10.in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded). Optionally
    // re-randomises out_ready each cycle while waiting.
    task automatic applyStimulus(input bit sel10, input logic [7:0] a, input logic [7:0] b,
                                 input logic tag, input bit randReady);
        bit accepted = 1'b0;
        for (int cyc = 0; cyc < 50 && !accepted; cyc++) begin
            if (sel10) begin
                bus10.in_valid = 1'b1;
                bus10.in_row_a = a;
                bus10.in_row_b = b;
                bus10.in_acc   = tag;
                if (randReady) bus10.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_row_a = a;
                bus.in_row_b = b;
                bus.in_acc   = tag;
                if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            accepted = sel10 ? (bus10.in_valid && bus10.in_ready) : (bus.in_valid && bus.in_ready);
            step();
        end
        compared++;
        if (!accepted) begin
            mismatched++;
            $display("[TB] FAIL accept_timeout: beat %h+%h not accepted within 50 cycles", a, b);
        end
    endtask

    task automatic waitDrain(output bit ok);
        bus.out_ready   = 1'b1;
        bus10.out_ready = 1'b1;
        ok = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (q16.size() == 0 && q10.size() == 0 && bus.out_valid === 1'b0 && bus10.out_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        idle();
        bus.out_ready   = 1'b0;
        bus10.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        compared += 6;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        if (bus.out_sum !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_out_sum: got %h, expected 0", bus.out_sum); end
        if (bus.out_acc !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_out_acc: got %h, expected 0", bus.out_acc); end
        if (bus.out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_ovf: got %b, expected 0", bus.out_ovf); end
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        if (bus10.in_ready !== 1'b1 || bus10.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_dut10: got in_ready %b out_valid %b, expected 1 0", bus10.in_ready, bus10.out_valid);
        end
    endtask

    task automatic test_single_beat();
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 8'h71, 8'h70, 1'b0, 1'b0);
        idle();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_valid: got %b, expected 0", bus.out_valid); end
        step();
        compared += 4;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b, expected 1", bus.out_valid); end
        if (bus.out_sum !== 9'h0E1) begin mismatched++; $display("[TB] FAIL single_sum: got %h, expected 0e1", bus.out_sum); end
        if (bus.out_acc !== 16'd225) begin mismatched++; $display("[TB] FAIL single_acc: got %0d, expected 225", bus.out_acc); end
        if (bus.out_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL single_ovf: got %b, expected 0", bus.out_ovf); end
        step();
    endtask

    task automatic test_carry();
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        idle();
        compared += 2;
        if (bus.out_sum !== 9'h100) begin mismatched++; $display("[TB] FAIL carry_lo_sum: got %h, expected 100", bus.out_sum); end
        if (bus.out_acc !== 16'd256) begin mismatched++; $display("[TB] FAIL carry_lo_acc: got %0d, expected 256", bus.out_acc); end
        step();
        compared += 3;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL back_to_back_valid: got %b, expected 1", bus.out_valid); end
        if (bus.out_sum !== 9'h1FE) begin mismatched++; $display("[TB] FAIL carry_ff_sum: got %h, expected 1fe", bus.out_sum); end
        if (bus.out_acc !== 16'd766) begin mismatched++; $display("[TB] FAIL carry_ff_acc: got %0d, expected 766", bus.out_acc); end
        step();
    endtask

    task automatic test_acc_wrap();
        bus10.out_ready = 1'b1;
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        compared++;
        if (bus10.out_acc !== 10'd510 || bus10.out_ovf !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wrap_load: got acc %0d ovf %b, expected 510 0", bus10.out_acc, bus10.out_ovf);
        end
        applyStimulus(1'b1, 8'h04, 8'h00, 1'b1, 1'b0);
        compared++;
        if (bus10.out_acc !== 10'd1020 || bus10.out_ovf !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wrap_1020: got acc %0d ovf %b, expected 1020 0", bus10.out_acc, bus10.out_ovf);
        end
        applyStimulus(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        idle();
        compared++;
        if (bus10.out_acc !== 10'd0 || bus10.out_ovf !== 1'b1) begin
            mismatched++; $display("[TB] FAIL wrap_overflow: got acc %0d ovf %b, expected 0 1", bus10.out_acc, bus10.out_ovf);
        end
        step();
        compared++;
        if (bus10.out_acc !== 10'd3 || bus10.out_ovf !== 1'b0 || bus10.out_sum !== 9'd3) begin
            mismatched++;
            $display("[TB] FAIL wrap_reload: got acc %0d ovf %b sum %0d, expected 3 0 3", bus10.out_acc, bus10.out_ovf, bus10.out_sum);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] ba[4] = '{8'h12, 8'h0F, 8'hA0, 8'h07};
        logic [7:0] bb[4] = '{8'h34, 8'h0F, 8'h05, 8'h09};
        logic       bt[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int  idx = 0;
        bit  ok;
        doReset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) begin
                bus.in_valid = 1'b1;
                bus.in_row_a = ba[idx];
                bus.in_row_b = bb[idx];
                bus.in_acc   = bt[idx];
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            step();
        end
        compared += 3;
        if (idx != 2) begin mismatched++; $display("[TB] FAIL bp_accepted: got %0d beats, expected 2", idx); end
        if (bus.in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready: got %b, expected 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd70 || bus.out_acc !== 16'd70) begin
            mismatched++;
            $display("[TB] FAIL bp_first: got valid %b sum %0d acc %0d, expected 1 70 70", bus.out_valid, bus.out_sum, bus.out_acc);
        end
        repeat (3) step();
        compared++;
        if (bus.out_sum !== 9'd70 || bus.out_acc !== 16'd70 || bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got sum %0d acc %0d in_ready %b, expected 70 70 0", bus.out_sum, bus.out_acc, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, ba[2], bb[2], bt[2], 1'b0);
        applyStimulus(1'b0, ba[3], bb[3], bt[3], 1'b0);
        idle();
        waitDrain(ok);
        compared += 2;
        if (!ok) begin mismatched++; $display("[TB] FAIL bp_drain: results still pending (q16 %0d)", q16.size()); end
        if (bus.out_acc !== 16'd281) begin mismatched++; $display("[TB] FAIL bp_final_acc: got %0d, expected 281", bus.out_acc); end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 8'h10, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h20, 8'h20, 1'b1, 1'b0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_row_a = 8'h09;
        bus.in_row_b = 8'h09;
        bus.in_acc   = 1'b0;
        step();
        rst = 1'b0;
        idle();
        compared++;
        if (bus.out_valid !== 1'b0 || bus.out_acc !== 16'd0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset: got valid %b acc %0d ovf %b in_ready %b, expected 0 0 0 1",
                     bus.out_valid, bus.out_acc, bus.out_ovf, bus.in_ready);
        end
        step();
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_drop: got valid %b, expected 0", bus.out_valid); end
        applyStimulus(1'b0, 8'h03, 8'h05, 1'b0, 1'b0);
        idle();
        step();
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd8 || bus.out_acc !== 16'd8) begin
            mismatched++;
            $display("[TB] FAIL midreset_after: got valid %b sum %0d acc %0d, expected 1 8 8", bus.out_valid, bus.out_sum, bus.out_acc);
        end
        step();
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        idle();
        waitDrain(ok);
        compared++;
        if (!ok) begin mismatched++; $display("[TB] FAIL random_drain: results still pending (q16 %0d)", q16.size()); end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_row_a    = '0;
        bus.in_row_b    = '0;
        bus.in_acc      = 1'b0;
        bus.out_ready   = 1'b0;
        bus10.in_valid  = 1'b0;
        bus10.in_row_a  = '0;
        bus10.in_row_b  = '0;
        bus10.in_acc    = 1'b0;
        bus10.out_ready = 1'b0;

        test_reset();
        test_single_beat();
        test_carry();
        test_acc_wrap();
        test_backpressure();
        test_reset_midflight();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
